// File: rtl/xadc_drp_arbiter.sv
// -----------------------------------------------------------------------------
// xadc_drp_arbiter
//
// Shares the single XADC DRP among NUM_REQ requesters. Requests are granted
// round-robin, one DRP transaction is outstanding at a time, and each
// transaction is aborted with an error response if DRDY does not arrive within
// TIMEOUT cycles of DEN.
//
// Ports:
//   clk, rst        clock (also XADC DCLK), synchronous active-high reset
//   req_valid/we    per-requester request pending / write select
//   req_addr        packed 7-bit DRP addresses, requester i at [7i+6:7i]
//   req_wdata       packed 16-bit write data, requester i at [16i+15:16i]
//   req_ready       one-hot accept pulse (combinational in IDLE)
//   rsp_valid       one-hot completion pulse
//   rsp_rdata/err   read data / timeout flag, held until the next rsp_valid
//   drp_*           XADC DRP pins (den/dwe/daddr/di out, do/drdy in)
//   stat_timeouts   saturating timeout-abort count
//   stat_stray      saturating count of DRDY seen outside WAIT
//
// Optional feature macro: XADC_DRP_STATS_EN builds the two statistics
// counters; when undefined the stat_* ports are tied to zero.
// -----------------------------------------------------------------------------
module xadc_drp_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_we,
    input  logic [NUM_REQ*7-1:0]    req_addr,
    input  logic [NUM_REQ*16-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [15:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic                    drp_den,
    output logic                    drp_dwe,
    output logic [6:0]              drp_daddr,
    output logic [15:0]             drp_di,
    input  logic [15:0]             drp_do,
    input  logic                    drp_drdy,
    output logic [15:0]             stat_timeouts,
    output logic [15:0]             stat_stray
);

    localparam int          PTR_W   = $clog2(NUM_REQ);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [PTR_W-1:0]     ptr_r;
    logic [PTR_W-1:0]     winner_s;
    logic                 any_req_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic [NUM_REQ-1:0]   owner_r;
    logic [15:0]          cnt_r;
    logic                 accept_s;
    logic                 done_ok_s;
    logic                 done_to_s;

    // Round-robin scan: first pending requester at or above the pointer, with wrap.
    always_comb begin
        any_req_s = 1'b0;
        winner_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int   idx;
            logic hit;
            idx       = (int'(ptr_r) + i) % NUM_REQ;
            hit       = !any_req_s && req_valid[idx];
            winner_s  = hit ? PTR_W'(idx) : winner_s;
            any_req_s = any_req_s | hit;
        end
    end

    // Next-state logic and single-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        done_ok_s   = 1'b0;
        done_to_s   = 1'b0;
        grant_s     = '0;
        case (state_r)
            IDLE: begin
                // rst gates the grant so no ready pulse escapes during reset
                if (any_req_s && !rst) begin
                    accept_s    = 1'b1;
                    grant_s     = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                // DRDY takes priority over a timeout landing on the same cycle
                if (drp_drdy) begin
                    done_ok_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else if (cnt_r == TO_LAST) begin
                    done_to_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign req_ready = grant_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Round-robin pointer: one past the last winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (accept_s) begin
            ptr_r <= (winner_s == PTR_W'(NUM_REQ - 1)) ? '0 : winner_s + 1'b1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // DRP pins load straight from the winner on accept, so they hold the latched
    // request for the single ISSUE cycle and return to zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r   <= '0;
            drp_den   <= 1'b0;
            drp_dwe   <= 1'b0;
            drp_daddr <= 7'd0;
            drp_di    <= 16'd0;
        end else begin
            owner_r   <= accept_s ? grant_s : owner_r;
            drp_den   <= accept_s;
            drp_dwe   <= accept_s & req_we[winner_s];
            drp_daddr <= accept_s ? req_addr[int'(winner_s)*7 +: 7] : 7'd0;
            drp_di    <= accept_s ? req_wdata[int'(winner_s)*16 +: 16] : 16'd0;
        end
    end

    // DRDY timeout counter: cleared in ISSUE, counts every WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 16'd0;
        end else if (state_r == ISSUE) begin
            cnt_r <= 16'd0;
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Response pulse; data and error flag hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= 16'd0;
            rsp_err   <= 1'b0;
        end else if (done_ok_s) begin
            rsp_valid <= owner_r;
            rsp_rdata <= drp_do;
            rsp_err   <= 1'b0;
        end else if (done_to_s) begin
            rsp_valid <= owner_r;
            rsp_rdata <= 16'd0;
            rsp_err   <= 1'b1;
        end else begin
            rsp_valid <= '0;
        end
    end

`ifdef XADC_DRP_STATS_EN
    logic [15:0] stat_to_r;
    logic [15:0] stat_stray_r;

    // Saturating timeout and stray-DRDY counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_to_r    <= 16'd0;
            stat_stray_r <= 16'd0;
        end else begin
            if (done_to_s && (stat_to_r != 16'hFFFF)) begin
                stat_to_r <= stat_to_r + 16'd1;
            end else begin
                stat_to_r <= stat_to_r;
            end
            if (drp_drdy && (state_r != WAIT) && (stat_stray_r != 16'hFFFF)) begin
                stat_stray_r <= stat_stray_r + 16'd1;
            end else begin
                stat_stray_r <= stat_stray_r;
            end
        end
    end

    assign stat_timeouts = stat_to_r;
    assign stat_stray    = stat_stray_r;
`else
    assign stat_timeouts = 16'h0000;
    assign stat_stray    = 16'h0000;
`endif

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xadc_drp_arbiter
//
// Directed, cycle-exact bench for xadc_drp_arbiter (NUM_REQ=3, TIMEOUT=64).
// Inputs are driven 2 ns after each rising edge and outputs are compared 1 ns
// later, well away from the active edge. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_xadc_drp_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_we;
    logic [20:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic [15:0] stat_timeouts;
    logic [15:0] stat_stray;

    int checks = 0;
    int errors = 0;
    int prev;
    int w;

`ifdef XADC_DRP_STATS_EN
    localparam logic [15:0] EXP_TO    = 16'd1;
    localparam logic [15:0] EXP_STRAY = 16'd1;
`else
    localparam logic [15:0] EXP_TO    = 16'd0;
    localparam logic [15:0] EXP_STRAY = 16'd0;
`endif

    xadc_drp_arbiter #(
        .NUM_REQ (3),
        .TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .drp_den       (drp_den),
        .drp_dwe       (drp_dwe),
        .drp_daddr     (drp_daddr),
        .drp_di        (drp_di),
        .drp_do        (drp_do),
        .drp_drdy      (drp_drdy),
        .stat_timeouts (stat_timeouts),
        .stat_stray    (stat_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic we, input logic [6:0] a, input logic [15:0] d);
        req_we[i]           = we;
        req_addr[i*7 +: 7]  = a;
        req_wdata[i*16 +: 16] = d;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 3'b111;
        req_we    = 3'b000;
        req_addr  = 21'd0;
        req_wdata = 48'd0;
        drp_do    = 16'd0;
        drp_drdy  = 1'b0;

        // ---- reset state: nothing granted even with all requests pending
        cyc();
        cyc();
        #1;
        check("rst_ready", req_ready, 3'b000);
        check("rst_den", drp_den, 1'b0);
        check("rst_rsp_valid", rsp_valid, 3'b000);
        check("rst_rdata", rsp_rdata, 16'h0000);
        check("rst_err", rsp_err, 1'b0);
        check("rst_stat_to", stat_timeouts, 16'h0000);
        check("rst_stat_stray", stat_stray, 16'h0000);
        req_valid = 3'b000;
        rst       = 1'b0;
        cyc();

        // ---- single read from requester 1, DRDY 5 cycles after DEN
        set_req(1, 1'b0, 7'h00, 16'h0000);
        req_valid = 3'b010;
        #1 check("rd_ready", req_ready, 3'b010);
        cyc();
        req_valid = 3'b000;
        #1;
        check("rd_den", drp_den, 1'b1);
        check("rd_dwe", drp_dwe, 1'b0);
        check("rd_daddr", drp_daddr, 7'h00);
        check("rd_ready_issue", req_ready, 3'b000);
        cyc();
        #1 check("rd_den_once", drp_den, 1'b0);
        cyc();
        cyc();
        cyc();
        cyc();
        drp_drdy = 1'b1;
        drp_do   = 16'h9A3C;
        #1 check("rd_rsp_early", rsp_valid, 3'b000);
        cyc();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        #1;
        check("rd_rsp_valid", rsp_valid, 3'b010);
        check("rd_rdata", rsp_rdata, 16'h9A3C);
        check("rd_err", rsp_err, 1'b0);
        cyc();
        #1;
        check("rd_rsp_pulse", rsp_valid, 3'b000);
        check("rd_rdata_hold", rsp_rdata, 16'h9A3C);

        // ---- write from requester 2 (pointer now 2)
        set_req(2, 1'b1, 7'h42, 16'h0800);
        req_valid = 3'b100;
        #1 check("wr_ready", req_ready, 3'b100);
        cyc();
        req_valid = 3'b000;
        #1;
        check("wr_den", drp_den, 1'b1);
        check("wr_dwe", drp_dwe, 1'b1);
        check("wr_daddr", drp_daddr, 7'h42);
        check("wr_di", drp_di, 16'h0800);
        cyc();
        #1;
        check("wr_dwe_idle", drp_dwe, 1'b0);
        check("wr_daddr_idle", drp_daddr, 7'h00);
        check("wr_di_idle", drp_di, 16'h0000);
        drp_drdy = 1'b1;
        drp_do   = 16'hABCD;
        cyc();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        #1;
        check("wr_rsp_valid", rsp_valid, 3'b100);
        check("wr_err", rsp_err, 1'b0);
        check("wr_rdata", rsp_rdata, 16'hABCD);
        req_we = 3'b000;
        cyc();

        // ---- fairness: all three pending, re-request after response
        for (int i = 0; i < 3; i++) begin
            set_req(i, 1'b0, 7'(7'h10 + i), 16'h0000);
        end
        req_valid = 3'b111;
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            w = k % 3;
            #1 check("rr_grant", req_ready, 32'd1 << w);
            cyc();
            req_valid[w] = 1'b0;
            if (prev >= 0) req_valid[prev] = 1'b1;
            #1;
            check("rr_den", drp_den, 1'b1);
            check("rr_daddr", drp_daddr, 32'(7'h10 + w));
            check("rr_no_accept", req_ready, 3'b000);
            cyc();
            cyc();
            drp_drdy = 1'b1;
            drp_do   = 16'(16'h1000 + k);
            cyc();
            drp_drdy = 1'b0;
            drp_do   = 16'h0000;
            if (k == 5) req_valid = 3'b000;
            #1;
            check("rr_rsp_valid", rsp_valid, 32'd1 << w);
            check("rr_rdata", rsp_rdata, 32'(16'h1000 + k));
            #1;
            prev = w;
        end
        cyc();

        // ---- timeout on requester 0, then a late stray DRDY
        set_req(0, 1'b0, 7'h03, 16'h0000);
        req_valid = 3'b001;
        #1 check("to_ready", req_ready, 3'b001);
        cyc();
        req_valid = 3'b000;
        #1 check("to_daddr", drp_daddr, 7'h03);
        for (int i = 0; i < 64; i++) begin
            cyc();
            #1 check("to_wait_quiet", rsp_valid, 3'b000);
        end
        cyc();
        #1;
        check("to_rsp_valid", rsp_valid, 3'b001);
        check("to_err", rsp_err, 1'b1);
        check("to_rdata", rsp_rdata, 16'h0000);
        cyc();
        drp_drdy = 1'b1;
        drp_do   = 16'h5555;
        cyc();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        #1;
        check("stray_rsp", rsp_valid, 3'b000);
        check("stray_err_hold", rsp_err, 1'b1);
        check("stray_rdata_hold", rsp_rdata, 16'h0000);
        check("stray_den", drp_den, 1'b0);
        check("stat_timeouts", stat_timeouts, EXP_TO);
        check("stat_stray", stat_stray, EXP_STRAY);

        // ---- DRDY on the timeout cycle: success wins (requester 1, pointer 1)
        set_req(1, 1'b0, 7'h05, 16'h0000);
        req_valid = 3'b010;
        #1 check("tie_ready", req_ready, 3'b010);
        cyc();
        req_valid = 3'b000;
        #1 check("tie_den", drp_den, 1'b1);
        for (int i = 0; i < 63; i++) begin
            cyc();
            #1 check("tie_wait_quiet", rsp_valid, 3'b000);
        end
        cyc();
        drp_drdy = 1'b1;
        drp_do   = 16'h1234;
        cyc();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        #1;
        check("tie_rsp_valid", rsp_valid, 3'b010);
        check("tie_err", rsp_err, 1'b0);
        check("tie_rdata", rsp_rdata, 16'h1234);
        check("tie_stat_to", stat_timeouts, EXP_TO);
        cyc();

        // ---- reset during WAIT (pointer 2, requester 0 wins by wrap)
        set_req(0, 1'b0, 7'h07, 16'h0000);
        req_valid = 3'b001;
        #1 check("mr_ready", req_ready, 3'b001);
        cyc();
        req_valid = 3'b000;
        cyc();
        rst = 1'b1;
        cyc();
        #1;
        check("mr_rsp_valid", rsp_valid, 3'b000);
        check("mr_den", drp_den, 1'b0);
        check("mr_rdata", rsp_rdata, 16'h0000);
        check("mr_err", rsp_err, 1'b0);
        check("mr_stat_to", stat_timeouts, 16'h0000);
        rst = 1'b0;
        cyc();
        #1;
        check("mr_no_reissue", drp_den, 1'b0);
        check("mr_no_rsp", rsp_valid, 3'b000);
        // pointer back at 0: requester 0 beats requester 2
        set_req(2, 1'b0, 7'h09, 16'h0000);
        req_valid = 3'b101;
        #1 check("mr_ptr0_grant", req_ready, 3'b001);
        cyc();
        req_valid = 3'b100;
        #1;
        check("mr_den", drp_den, 1'b1);
        check("mr_daddr", drp_daddr, 7'h07);
        cyc();
        drp_drdy = 1'b1;
        drp_do   = 16'h0F0F;
        cyc();
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        #1;
        check("mr_rsp_valid2", rsp_valid, 3'b001);
        check("mr_rdata2", rsp_rdata, 16'h0F0F);
        check("mr_accept_with_rsp", req_ready, 3'b100);
        cyc();
        req_valid = 3'b000;
        #1;
        check("mr_den2", drp_den, 1'b1);
        check("mr_daddr2", drp_daddr, 7'h09);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
